// File: rtl/tnet_pkg.sv
// ---------------------------------------------------------------------------
// tnet_pkg
// Shared definitions for the tnet receive path.
//   - Bit positions of the header and data fields inside the two 64-bit beats
//     of a tnet packet.
//   - tnet_rx_state_t : framing FSM states of the RX packet decoder.
//   - tnet_pkt_t      : decoded packet as presented to the command logic.
// ---------------------------------------------------------------------------
package tnet_pkg;

   // Beat 0 layout: {op, rsvd, dst, src, rsvd, dt1}
   localparam int OP_MSB  = 63;
   localparam int OP_LSB  = 59;
   localparam int DST_MSB = 55;
   localparam int DST_LSB = 48;
   localparam int SRC_MSB = 47;
   localparam int SRC_LSB = 40;
   localparam int DT1_MSB = 31;
   localparam int DT1_LSB = 0;

   // Beat 1 layout: {dt2, dt3}
   localparam int DT2_MSB = 63;
   localparam int DT2_LSB = 32;
   localparam int DT3_MSB = 31;
   localparam int DT3_LSB = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      DROP = 2'd2
   } tnet_rx_state_t;

   typedef struct packed {
      logic [4:0]  op;
      logic [7:0]  src;
      logic        bcast;
      logic [31:0] dt1;
      logic [31:0] dt2;
      logic [31:0] dt3;
   } tnet_pkt_t;

endpackage

// File: rtl/tnet_sat_cnt.sv
// ---------------------------------------------------------------------------
// tnet_sat_cnt
// Event counter that sticks at all-ones instead of wrapping, so a saturated
// statistics value is never mistaken for a small one.
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   synchronous active-low reset, clears the count
//   inc    in   1   count one event this cycle
//   cnt    out  DW  current count
// ---------------------------------------------------------------------------
module tnet_sat_cnt #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [DW-1:0] cnt
);

   // Increment on each event until every bit is set, then hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {DW{1'b1}})) begin
         cnt <= cnt + DW'(1);
      end
   end

endmodule

// File: rtl/tnet_rx_pkt_decoder.sv
// ---------------------------------------------------------------------------
// tnet_rx_pkt_decoder
// Receive-side packet decoder for the simplex tnet link. Frames 2-beat
// packets from the Aurora RX user stream (no backpressure), filters them by
// destination ID and hands decoded commands to the control logic through a
// 1-entry holding register with a valid/ready handshake.
//
// Optional build: define TNET_RX_STATS_EN to add four saturating statistics
// counters (ok / err / drop / ovf) and their cnt_*_o ports.
//
// Ports:
//   c_clk_i       in   1      core clock (Aurora user clock)
//   c_rst_ni      in   1      synchronous active-low reset
//   channel_up_i  in   1      Aurora channel up; low aborts any partial packet
//   cfg_id_i      in   8      local node ID
//   rx_tvalid_i   in   1      RX beat valid
//   rx_tdata_i    in   64     RX beat data
//   rx_tlast_i    in   1      RX end of packet
//   pkt_valid_o   out  1      decoded packet available
//   pkt_ready_i   in   1      consumer takes the packet
//   pkt_op_o      out  5      command opcode
//   pkt_src_o     out  8      source node ID
//   pkt_bcast_o   out  1      packet was addressed to BCAST_ID
//   pkt_dt1/2/3_o out  32     data words
//   rx_err_o      out  1      one-cycle pulse per framing error
//   cnt_ok_o / cnt_err_o / cnt_drop_o / cnt_ovf_o  out CNT_DW (stats build)
// ---------------------------------------------------------------------------
module tnet_rx_pkt_decoder
   import tnet_pkg::*;
#(
   parameter int         CNT_DW   = 16,
   parameter logic [7:0] BCAST_ID = 8'hFF
) (
   input  logic        c_clk_i,
   input  logic        c_rst_ni,
   input  logic        channel_up_i,
   input  logic [7:0]  cfg_id_i,
   input  logic        rx_tvalid_i,
   input  logic [63:0] rx_tdata_i,
   input  logic        rx_tlast_i,
   output logic        pkt_valid_o,
   input  logic        pkt_ready_i,
   output logic [4:0]  pkt_op_o,
   output logic [7:0]  pkt_src_o,
   output logic        pkt_bcast_o,
   output logic [31:0] pkt_dt1_o,
   output logic [31:0] pkt_dt2_o,
   output logic [31:0] pkt_dt3_o,
   output logic        rx_err_o
`ifdef TNET_RX_STATS_EN
   ,
   output logic [CNT_DW-1:0] cnt_ok_o,
   output logic [CNT_DW-1:0] cnt_err_o,
   output logic [CNT_DW-1:0] cnt_drop_o,
   output logic [CNT_DW-1:0] cnt_ovf_o
`endif
);

   tnet_rx_state_t state, state_nxt;

   logic [4:0]  hdr_op;
   logic [7:0]  hdr_dst;
   logic [7:0]  hdr_src;
   logic [31:0] hdr_dt1;

   logic        hdr_load;
   logic        pkt_done;
   logic        frm_err;
   logic        dst_match;
   logic        pkt_accept;
   logic        pkt_load;

   tnet_pkt_t   pkt_q;
   logic        pkt_valid_q;
   logic        rx_err_q;

   // Framing state register. Reset mid-packet lands in IDLE, which is what
   // discards the partial packet.
   always_ff @(posedge c_clk_i) begin
      if (!c_rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Framing decisions. Only beats move the FSM; a dropped channel throws
   // away whatever was in flight without flagging an error, since the link
   // going down is not a framing fault of the sender.
   always_comb begin
      state_nxt = state;
      hdr_load  = 1'b0;
      pkt_done  = 1'b0;
      frm_err   = 1'b0;
      if (!channel_up_i) begin
         state_nxt = IDLE;
      end else if (rx_tvalid_i) begin
         unique case (state)
            IDLE: begin
               if (rx_tlast_i) begin
                  frm_err = 1'b1;
               end else begin
                  hdr_load  = 1'b1;
                  state_nxt = DATA;
               end
            end
            DATA: begin
               if (rx_tlast_i) begin
                  pkt_done  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frm_err   = 1'b1;
                  state_nxt = DROP;
               end
            end
            DROP: begin
               if (rx_tlast_i) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Header capture from beat 0; reserved bits are simply not stored.
   always_ff @(posedge c_clk_i) begin
      if (!c_rst_ni) begin
         hdr_op  <= '0;
         hdr_dst <= '0;
         hdr_src <= '0;
         hdr_dt1 <= '0;
      end else if (hdr_load) begin
         hdr_op  <= rx_tdata_i[OP_MSB:OP_LSB];
         hdr_dst <= rx_tdata_i[DST_MSB:DST_LSB];
         hdr_src <= rx_tdata_i[SRC_MSB:SRC_LSB];
         hdr_dt1 <= rx_tdata_i[DT1_MSB:DT1_LSB];
      end
   end

   // A completed packet is ours if it targets this node or the broadcast ID.
   // It may only enter the holding register if the slot is empty or being
   // emptied this very cycle; otherwise the older packet wins.
   assign dst_match  = (hdr_dst == cfg_id_i) || (hdr_dst == BCAST_ID);
   assign pkt_accept = pkt_done && dst_match;
   assign pkt_load   = pkt_accept && (!pkt_valid_q || pkt_ready_i);

   // Holding register. Loading takes priority over the handshake clear so a
   // back-to-back packet keeps valid high across the read.
   always_ff @(posedge c_clk_i) begin
      if (!c_rst_ni) begin
         pkt_valid_q <= 1'b0;
         pkt_q       <= '0;
      end else if (pkt_load) begin
         pkt_valid_q <= 1'b1;
         pkt_q       <= '{op:    hdr_op,
                          src:   hdr_src,
                          bcast: (hdr_dst == BCAST_ID),
                          dt1:   hdr_dt1,
                          dt2:   rx_tdata_i[DT2_MSB:DT2_LSB],
                          dt3:   rx_tdata_i[DT3_MSB:DT3_LSB]};
      end else if (pkt_ready_i) begin
         pkt_valid_q <= 1'b0;
      end
   end

   // Registered error pulse, aligned with the packet output latency.
   always_ff @(posedge c_clk_i) begin
      if (!c_rst_ni) begin
         rx_err_q <= 1'b0;
      end else begin
         rx_err_q <= frm_err;
      end
   end

   assign pkt_valid_o = pkt_valid_q;
   assign pkt_op_o    = pkt_q.op;
   assign pkt_src_o   = pkt_q.src;
   assign pkt_bcast_o = pkt_q.bcast;
   assign pkt_dt1_o   = pkt_q.dt1;
   assign pkt_dt2_o   = pkt_q.dt2;
   assign pkt_dt3_o   = pkt_q.dt3;
   assign rx_err_o    = rx_err_q;

`ifdef TNET_RX_STATS_EN
   logic pkt_drop;
   logic pkt_ovf;

   assign pkt_drop = pkt_done && !dst_match;
   assign pkt_ovf  = pkt_accept && pkt_valid_q && !pkt_ready_i;

   tnet_sat_cnt #(.DW(CNT_DW)) u_cnt_ok (
      .clk(c_clk_i), .rst_n(c_rst_ni), .inc(pkt_load), .cnt(cnt_ok_o)
   );
   tnet_sat_cnt #(.DW(CNT_DW)) u_cnt_err (
      .clk(c_clk_i), .rst_n(c_rst_ni), .inc(frm_err), .cnt(cnt_err_o)
   );
   tnet_sat_cnt #(.DW(CNT_DW)) u_cnt_drop (
      .clk(c_clk_i), .rst_n(c_rst_ni), .inc(pkt_drop), .cnt(cnt_drop_o)
   );
   tnet_sat_cnt #(.DW(CNT_DW)) u_cnt_ovf (
      .clk(c_clk_i), .rst_n(c_rst_ni), .inc(pkt_ovf), .cnt(cnt_ovf_o)
   );
`endif

endmodule
